// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//
// Parallel-in / serial-out converter on valid/ready streams. One DATAWIDTH
// word is accepted per input handshake and emitted as N = DATAWIDTH/LANEWIDTH
// output beats of LANEWIDTH bits each. dout_last marks the final beat of a
// word. A new word may be accepted in the same cycle the final beat of the
// previous word is taken, so back-to-back words stream without a bubble.
//
// Parameters:
//   DATAWIDTH  input word width (must be a multiple of LANEWIDTH)
//   LANEWIDTH  bits per output beat (1 = true bit-serial)
//   MSB_FIRST  0: least-significant lane first, 1: most-significant lane first
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active-high
//   din_valid   input word valid
//   din_ready   block can accept a word this cycle
//   din_data    input word
//   dout_valid  output beat valid
//   dout_ready  downstream accepts the beat
//   dout_data   current lane
//   dout_last   high on the final beat of a word
//   dout_rail   (only with PISO_STREAM_DUAL_RAIL_EN) dual-rail encoding of the
//               lane during a transfer, all-zero spacer otherwise
//
// Optional feature macro: PISO_STREAM_DUAL_RAIL_EN
// -----------------------------------------------------------------------------
module piso_stream #(
  parameter int DATAWIDTH = 16,
  parameter int LANEWIDTH = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [DATAWIDTH-1:0]   din_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [LANEWIDTH-1:0]   dout_data,
  output logic                   dout_last
`ifdef PISO_STREAM_DUAL_RAIL_EN
  ,
  output logic [2*LANEWIDTH-1:0] dout_rail
`endif
);

  localparam int N        = DATAWIDTH / LANEWIDTH;
  localparam int CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  // With a single lane the register is never advanced; keep the shift
  // amount in range so the unused expression stays well formed.
  localparam int SHAMT    = (N > 1) ? LANEWIDTH : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATAWIDTH-1:0]   r_shift;
  logic [DATAWIDTH-1:0]   w_shift_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_last;
  logic                   w_busy;

  // Lane presented at the output end of the shift register.
  function automatic logic [LANEWIDTH-1:0] f_lane(input logic [DATAWIDTH-1:0] word);
    if (MSB_FIRST) begin
      return word[DATAWIDTH-1 -: LANEWIDTH];
    end else begin
      return word[LANEWIDTH-1:0];
    end
  endfunction

  // Move the next lane to the output end, zero-filling behind it.
  function automatic logic [DATAWIDTH-1:0] f_advance(input logic [DATAWIDTH-1:0] word);
    if (N == 1) begin
      return '0;
    end else if (MSB_FIRST) begin
      return word << SHAMT;
    end else begin
      return word >> SHAMT;
    end
  endfunction

  assign w_busy     = (r_state == SHIFT);
  assign w_last     = w_busy & (r_cnt == LAST_CNT);
  assign w_out_fire = w_busy & dout_ready;
  // The only combinational dout_ready -> din_ready path: the slot frees up
  // exactly when the final beat of the current word is taken.
  assign din_ready  = ~rst & (~w_busy | (w_out_fire & w_last));
  assign w_in_fire  = din_valid & din_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_shift_nxt = din_data;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_out_fire) begin
          if (!w_last) begin
            w_shift_nxt = f_advance(r_shift);
            w_cnt_nxt   = r_cnt + CW'(1);
          end else if (w_in_fire) begin
            // Reload on the final beat: next word starts without a bubble.
            w_shift_nxt = din_data;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic; everything is a function of registered state only, so
  // dout_* never depend on dout_ready and hold stable under backpressure.
  always_comb begin
    dout_valid = w_busy;
    dout_last  = w_last;
    dout_data  = w_busy ? f_lane(r_shift) : '0;
  end

`ifdef PISO_STREAM_DUAL_RAIL_EN
  // Dual-rail pair per lane bit: (true, false) rails, both low as spacer.
  for (genvar gi = 0; gi < LANEWIDTH; gi++) begin : g_rail
    assign dout_rail[2*gi]   =  dout_data[gi] & w_out_fire;
    assign dout_rail[2*gi+1] = ~dout_data[gi] & w_out_fire;
  end
`endif

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out converter on valid/ready streams. Next generation of the team's bit-serial PISO.
- Accepts one DATAWIDTH word per input handshake. Emits it as DATAWIDTH/LANEWIDTH output beats of LANEWIDTH bits each, with a frame-end marker on the final beat.
- Supports selectable bit order and full-throughput back-to-back words.
- Sits between a word-wide producer and a narrow serial link or encoder.

Parameters:
- DATAWIDTH, 16, input word width; must be a multiple of LANEWIDTH.
- LANEWIDTH, 4, bits per output beat; 1 gives true bit-serial output.
- MSB_FIRST, 0, 0 = least-significant lane sent first; 1 = most-significant lane sent first.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- din_valid  input  1  input word valid
- din_ready  output  1  block can accept a word this cycle
- din_data  input  DATAWIDTH  input word
- dout_valid  output  1  output beat valid
- dout_ready  input  1  downstream accepts beat
- dout_data  output  LANEWIDTH  current lane
- dout_last  output  1  high on the final beat of a word

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Definitions: N = DATAWIDTH/LANEWIDTH. Beat counter width is max(1, clog2(N)). in_fire = din_valid & din_ready. out_fire = dout_valid & dout_ready.
- Storage: one DATAWIDTH shift register, beat counter, busy flag. State is IDLE (busy=0) or SHIFT (busy=1).
- Reset (rst=1 at clock edge):
  - busy=0, counter=0, shift register=0.
  - dout_valid=0, dout_last=0, dout_data=0.
  - din_ready is forced 0 while rst is high.
- din_ready = ~rst & (~busy | (out_fire & dout_last)). This is the only combinational path from dout_ready to din_ready.
- IDLE: on in_fire, load din_data and counter=0, then go to SHIFT. The first beat is valid the next cycle (1-cycle latency).
- SHIFT:
  - dout_valid=1.
  - dout_data = low LANEWIDTH bits of the register (MSB_FIRST=0) or high LANEWIDTH bits (MSB_FIRST=1).
  - dout_last = (counter == N-1).
- On out_fire with dout_last=0: shift the register by LANEWIDTH toward the output end, zero-filling, and increment the counter.
- On out_fire with dout_last=1:
  - If in_fire in the same cycle: load the new word, counter=0, stay in SHIFT. This gives back-to-back words with no bubble.
  - Otherwise go to IDLE.
- Backpressure: while dout_valid & ~dout_ready, dout_data, dout_last and the counter hold stable.
- dout_valid never depends combinationally on dout_ready.
- N=1 (LANEWIDTH==DATAWIDTH): every beat is last; the block behaves as a 1-deep register slice.
- din_data is ignored when in_fire=0. No word is ever dropped or duplicated.
- Reset mid-word discards the partial word; no further beats of it are emitted.

Optional Feature:
- Macro: PISO_STREAM_DUAL_RAIL_EN.
- When defined:
  - Adds output port dout_rail, width 2*LANEWIDTH.
  - For lane bit i: dout_rail[2i] = dout_data[i] & out_fire and dout_rail[2i+1] = ~dout_data[i] & out_fire.
  - With no transfer the port is all-zero (spacer).
  - Reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles with din_valid=1 -> din_ready=0, dout_valid=0, no load. First cycle after release -> din_ready=1.
- LSB-first word, defaults, dout_ready=1: load 16'hA5C3 -> beats 4'h3, 4'hC, 4'h5, 4'hA on 4 consecutive cycles starting 1 cycle after in_fire; dout_last only on 4'hA.
- MSB_FIRST=1, same stimulus -> beats 4'hA, 4'h5, 4'hC, 4'h3; dout_last on 4'h3.
- Back-to-back 16'h1234 then 16'h5678, din_valid and dout_ready held 1 -> 8 contiguous beats 4,3,2,1,8,7,6,5 with no bubble; din_ready=1 only during each last beat.
- Backpressure: dout_ready pattern 1,0,0,1,1 on word 16'hBEEF -> beat 4'hE held stable for 3 cycles; total 4 beats F,E,E,B; no loss or duplication.
- rst asserted after 2 beats of 16'hCAFE -> dout_valid=0 next cycle. Subsequent word 16'h0001 emits 1,0,0,0; with PISO_STREAM_DUAL_RAIL_EN, the first beat gives dout_rail=8'b10101001.
